// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: round-robin front-end sharing one data-cache port among N requesters
module dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PORTS  = 3,
  parameter int TIMEOUT    = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              c_req_valid,
  input  logic                              c_req_ready,
  output logic                              c_wen,
  output logic [ADDR_WIDTH-1:0]             c_addr,
  output logic [DATA_WIDTH-1:0]             c_wdata,
  output logic [DATA_WIDTH/8-1:0]           c_wmask,
  input  logic                              c_rsp_valid,
  input  logic [DATA_WIDTH-1:0]             c_rsp_rdata
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int MW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d, grant_q, grant_d, nxt_ptr, g, idx;
  logic [PW:0]            sum;
  logic [WW-1:0]          wdog_q, wdog_d;
  logic                   found, sel_wen;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [MW-1:0]          sel_wmask;
  logic                   c_req_valid_q, c_req_valid_d, c_wen_q, c_wen_d;
  logic [ADDR_WIDTH-1:0]  c_addr_q, c_addr_d;
  logic [DATA_WIDTH-1:0]  c_wdata_q, c_wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [MW-1:0]          c_wmask_q, c_wmask_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  // round-robin search from rr_ptr; descending scan so the nearest requester wins
  always_comb begin
    found = 1'b0;
    g = '0;
    sum = '0;
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NUM_PORTS)) ? PW'(sum - (PW+1)'(NUM_PORTS)) : PW'(sum);
      if (req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  // mux the winning port's request fields
  always_comb begin
    sel_wen = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (g == PW'(i)) begin
        sel_wen = req_wen[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask = req_wmask[i*MW +: MW];
      end
    end
  end
  assign req_ready = (state_q == IDLE && found) ? NUM_PORTS'(1) << g : '0;
  assign nxt_ptr = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
  // next-state: accept in IDLE, hold request until handshake, complete or time out in WAIT
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    wdog_d = wdog_q;
    c_req_valid_d = c_req_valid_q;
    c_wen_d = c_wen_q;
    c_addr_d = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_wmask_d = c_wmask_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        grant_d = g;
        c_req_valid_d = 1'b1;
        c_wen_d = sel_wen;
        c_addr_d = sel_addr;
        c_wdata_d = sel_wdata;
        c_wmask_d = sel_wmask;
      end
      ISSUE: if (c_req_ready) begin
        state_d = WAIT;
        c_req_valid_d = 1'b0;
        wdog_d = '0;
      end
      WAIT: if (c_rsp_valid) begin
        state_d = IDLE;
        rsp_valid_d = NUM_PORTS'(1) << grant_q;
        rsp_rdata_d = c_rsp_rdata;
        rr_ptr_d = nxt_ptr;
      end else if (TIMEOUT != 0 && wdog_q == WW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        rsp_valid_d = NUM_PORTS'(1) << grant_q;
        rsp_err_d = 1'b1;
        rr_ptr_d = nxt_ptr;
      end else begin
        wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset drops any in-flight transaction silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      wdog_q <= '0;
      c_req_valid_q <= 1'b0;
      c_wen_q <= 1'b0;
      c_addr_q <= '0;
      c_wdata_q <= '0;
      c_wmask_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      wdog_q <= wdog_d;
      c_req_valid_q <= c_req_valid_d;
      c_wen_q <= c_wen_d;
      c_addr_q <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_wmask_q <= c_wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign c_req_valid = c_req_valid_q;
  assign c_wen = c_wen_q;
  assign c_addr = c_addr_q;
  assign c_wdata = c_wdata_q;
  assign c_wmask = c_wmask_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed and random transactions against a transaction-level model
module tb_dcache_port_arbiter;
  localparam int AW = 64, DW = 64, N = 3, MW = 8, TO = 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready, req_wen, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*MW-1:0] req_wmask;
  logic [DW-1:0] rsp_rdata, c_wdata, c_rsp_rdata;
  logic rsp_err, c_req_valid, c_req_ready, c_wen, c_rsp_valid;
  logic [AW-1:0] c_addr;
  logic [MW-1:0] c_wmask;
  int checks = 0, errors = 0, ptr = 0;
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_wdata[N];
  logic [MW-1:0] p_wmask[N];
  logic p_wen[N];
  logic [N-1:0] want;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .c_req_valid(c_req_valid), .c_req_ready(c_req_ready),
    .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = want[i];
      req_wen[i] = p_wen[i];
      req_addr[i*AW +: AW] = p_addr[i];
      req_wdata[i*DW +: DW] = p_wdata[i];
      req_wmask[i*MW +: MW] = p_wmask[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic randomize_ports();
    for (int i = 0; i < N; i++) begin
      p_addr[i] = {$urandom, $urandom};
      p_wdata[i] = {$urandom, $urandom};
      p_wmask[i] = 8'($urandom);
      p_wen[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // one complete transaction: accept, issue (with acc_dly stall cycles), wait rsp_dly cycles
  task automatic txn(input int acc_dly, input int rsp_dly, input logic [DW-1:0] rd, input logic drop);
    int g, n;
    logic to, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [MW-1:0] em;
    drive();
    #1;
    g = pick(want, ptr);
    check("req_ready", 64'(req_ready), 64'(1) << g);
    ea = p_addr[g];
    ed = p_wdata[g];
    em = p_wmask[g];
    ew = p_wen[g];
    if (drop) want[g] = 1'b0;
    cyc();
    drive();
    for (int i = 0; i <= acc_dly; i++) begin
      c_req_ready = (i == acc_dly);
      #1;
      check("c_req_valid", 64'(c_req_valid), 64'(1));
      check("c_addr", c_addr, ea);
      check("c_wdata", c_wdata, ed);
      check("c_wmask", 64'(c_wmask), 64'(em));
      check("c_wen", 64'(c_wen), 64'(ew));
      check("ready_busy", 64'(req_ready), 64'(0));
      check("rsp_early", 64'(rsp_valid), 64'(0));
      cyc();
    end
    c_req_ready = 1'b0;
    to = (rsp_dly >= TO);
    n = to ? TO : rsp_dly + 1;
    for (int w = 0; w < n; w++) begin
      c_rsp_valid = (w == rsp_dly);
      c_rsp_rdata = (w == rsp_dly) ? rd : {$urandom, $urandom};
      #1;
      check("c_req_valid_wait", 64'(c_req_valid), 64'(0));
      check("ready_wait", 64'(req_ready), 64'(0));
      check("rsp_wait", 64'(rsp_valid), 64'(0));
      cyc();
    end
    c_rsp_valid = 1'b0;
    c_rsp_rdata = {$urandom, $urandom};
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(1) << g);
    check("rsp_rdata", rsp_rdata, to ? 64'(0) : rd);
    check("rsp_err", 64'(rsp_err), 64'(to));
    ptr = (g + 1) % N;
  endtask

  initial begin
    rst = 1'b1;
    want = '0;
    c_req_ready = 1'b0;
    c_rsp_valid = 1'b0;
    c_rsp_rdata = '0;
    randomize_ports();
    drive();
    repeat (3) cyc();
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_c_req_valid", 64'(c_req_valid), 64'(0));
    check("rst_c_addr", c_addr, 64'(0));
    check("rst_c_wdata", c_wdata, 64'(0));
    check("rst_c_wmask", 64'(c_wmask), 64'(0));
    check("rst_c_wen", 64'(c_wen), 64'(0));
    check("rst_rsp_rdata", rsp_rdata, 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    // single read on port 1, minimum latency
    p_addr[1] = 64'h8000_1000;
    p_wen[1] = 1'b0;
    want = 3'b010;
    txn(0, 0, 64'hDEAD_BEEF, 1'b1);
    // write on port 0, then a spurious cache response while idle
    p_wen[0] = 1'b1;
    p_wmask[0] = 8'h0F;
    p_wdata[0] = 64'h1122_3344_5566_7788;
    want = 3'b001;
    txn(0, 0, {$urandom, $urandom}, 1'b1);
    want = '0;
    drive();
    c_rsp_valid = 1'b1;
    #1;
    check("spurious_ready", 64'(req_ready), 64'(0));
    cyc();
    c_rsp_valid = 1'b0;
    #1;
    check("spurious_rsp", 64'(rsp_valid), 64'(0));
    check("spurious_c_req", 64'(c_req_valid), 64'(0));
    // cache stalls acceptance for 5 cycles
    randomize_ports();
    want = 3'b100;
    txn(5, 1, {$urandom, $urandom}, 1'b1);
    // response on the last wait cycle wins over the watchdog
    want = 3'b011;
    txn(0, TO - 1, 64'hCAFE_F00D_0000_0001, 1'b1);
    // silent cache: watchdog error, then a normal transaction
    want = 3'b010;
    txn(0, 50, {$urandom, $urandom}, 1'b1);
    want = 3'b010;
    txn(1, 2, 64'h0123_4567_89AB_CDEF, 1'b1);
    // reset while waiting drops the transaction and restarts arbitration at port 0
    randomize_ports();
    want = 3'b100;
    drive();
    #1;
    check("pre_rst_ready", 64'(req_ready), 64'(1) << pick(want, ptr));
    cyc();
    c_req_ready = 1'b1;
    cyc();
    c_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    want = '0;
    drive();
    #1;
    check("mid_rst_c_req", 64'(c_req_valid), 64'(0));
    check("mid_rst_c_addr", c_addr, 64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    c_rsp_valid = 1'b1;
    c_rsp_rdata = 64'h5555_AAAA_5555_AAAA;
    cyc();
    c_rsp_valid = 1'b0;
    #1;
    check("post_rst_rsp", 64'(rsp_valid), 64'(0));
    check("post_rst_err", 64'(rsp_err), 64'(0));
    ptr = 0;
    // all ports requesting continuously: strict rotation from port 0
    want = 3'b111;
    repeat (6) txn(0, 0, {$urandom, $urandom}, 1'b0);
    // random traffic
    for (int t = 0; t < 40; t++) begin
      int r;
      randomize_ports();
      want = N'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (want == '0) begin
        drive();
        c_rsp_valid = 1'($urandom_range(0, 1));
        #1;
        check("idle_ready", 64'(req_ready), 64'(0));
        cyc();
        c_rsp_valid = 1'b0;
        #1;
        check("idle_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        txn($urandom_range(0, 3), r < 6 ? r % 4 : (r == 6 ? TO - 1 : (r == 7 ? TO : 15)),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
